uart_hello_sender: RTL and testbench

Transmit-side counterpart of the board's UART word-detect path. On a one-clock `send` pulse it serializes the fixed ASCII message "hello\r\n" as 8N1 UART frames on `tx`. Each frame is start bit, 8 data bits LSB first, stop bit. The message is 7 bytes: 0x68 0x65 0x6C 0x6C 0x6F 0x0D 0x0A. Used for board-to-board or loopback testing against the word detector; it also reports progress to other logic.

---
 rtl/uart_hello_sender.sv | 179 +++++++++++++++++
 tb/tb_uart_hello_sender.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_hello_sender.sv
// -----------------------------------------------------------------------------
// uart_hello_sender
//
// On a one-clock send request this block transmits the fixed ASCII message
// "hello\r\n" (0x68 0x65 0x6C 0x6C 0x6F 0x0D 0x0A) as back-to-back UART frames
// on tx. Each frame is a start bit, 8 data bits LSB first and a stop bit.
//
// Optional feature, macro UART_TX_PARITY_EN:
//   defined   - an even parity bit (XOR of the data byte) follows the data
//               bits, giving 11-bit frames.
//   undefined - plain 8N1, 10-bit frames.
//
// Parameters:
//   CLK_FREQ  system clock frequency in Hz
//   BAUD      line rate in bits/s; CLKS_PER_BIT = CLK_FREQ / BAUD must be >= 2
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-high
//   send      one-clock request to transmit the whole message
//   tx        UART serial line, idles high
//   busy      high while a message is on the line
//   done      one-clock pulse after the final stop bit
//   tx_byte   byte currently being transmitted (holds 0x0A after completion)
//   byte_idx  index 0..6 of the current byte
// -----------------------------------------------------------------------------
module uart_hello_sender #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       send,
   output logic       tx,
   output logic       busy,
   output logic       done,
   output logic [7:0] tx_byte,
   output logic [2:0] byte_idx
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       LAST_IDX = 3'd6;

   generate
      if (CLKS_PER_BIT < 2) begin : g_bad_baud
         $error("uart_hello_sender: CLK_FREQ / BAUD must be at least 2");
      end
   endgenerate

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_FINISH} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_FINISH} state_t;
`endif

   // Message ROM as a constant function: pure logic, nothing to reset.
   function automatic logic [7:0] msg_byte(input logic [2:0] idx);
      case (idx)
         3'd0:    msg_byte = 8'h68;  // 'h'
         3'd1:    msg_byte = 8'h65;  // 'e'
         3'd2:    msg_byte = 8'h6C;  // 'l'
         3'd3:    msg_byte = 8'h6C;  // 'l'
         3'd4:    msg_byte = 8'h6F;  // 'o'
         3'd5:    msg_byte = 8'h0D;  // '\r'
         3'd6:    msg_byte = 8'h0A;  // '\n'
         default: msg_byte = 8'h00;
      endcase
   endfunction

   state_t           state;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_cnt;
   logic [2:0]       next_bit;
   logic             bit_end;

   assign bit_end  = (baud_cnt == LAST_CNT);
   assign next_bit = bit_cnt + 3'd1;

   // NOTE: all state below uses non-blocking assignments so every register
   // samples the pre-edge values; the later assignment in a branch (e.g. done)
   // legitimately overrides the default given at the top of the block.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         tx       <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         tx_byte  <= 8'h00;
         byte_idx <= 3'd0;
         bit_cnt  <= 3'd0;
         baud_cnt <= '0;
      end else begin
         done <= 1'b0;
         // Baud counter free-runs through every line state and wraps at the
         // bit boundary, so consecutive bits and frames abut with no gap.
         if (state != S_IDLE && state != S_FINISH)
            baud_cnt <= bit_end ? '0 : baud_cnt + CNT_W'(1);

         case (state)
            S_IDLE: begin
               tx   <= 1'b1;
               busy <= 1'b0;
               if (send) begin
                  state    <= S_START;
                  tx       <= 1'b0;
                  busy     <= 1'b1;
                  byte_idx <= 3'd0;
                  tx_byte  <= msg_byte(3'd0);
                  baud_cnt <= '0;
               end
            end

            S_START: begin
               if (bit_end) begin
                  state   <= S_DATA;
                  bit_cnt <= 3'd0;
                  tx      <= tx_byte[0];
               end
            end

            S_DATA: begin
               if (bit_end) begin
                  if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state <= S_PARITY;
                     tx    <= ^tx_byte;
`else
                     state <= S_STOP;
                     tx    <= 1'b1;
`endif
                  end else begin
                     bit_cnt <= next_bit;
                     tx      <= tx_byte[next_bit];
                  end
               end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (bit_end) begin
                  state <= S_STOP;
                  tx    <= 1'b1;
               end
            end
`endif

            S_STOP: begin
               if (bit_end) begin
                  if (byte_idx < LAST_IDX) begin
                     state    <= S_START;
                     tx       <= 1'b0;
                     byte_idx <= byte_idx + 3'd1;
                     tx_byte  <= msg_byte(byte_idx + 3'd1);
                  end else begin
                     state <= S_FINISH;
                     tx    <= 1'b1;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end

            // One-cycle completion state; a send seen here is dropped.
            S_FINISH: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
               tx    <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_hello_sender.sv
// -----------------------------------------------------------------------------
// tb_uart_hello_sender
//
// Self-checking bench for uart_hello_sender at CLKS_PER_BIT = 10
// (CLK_FREQ = 1000, BAUD = 100). Follows UART_TX_PARITY_EN when defined.
// Each transmission is logged cycle by cycle (cycle 1 = first cycle after the
// edge that accepts send) and then checked against a vector table and a
// mid-bit decoder.
// -----------------------------------------------------------------------------
module tb_uart_hello_sender;

   localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
   localparam int FB  = 11;
`else
   localparam int FB  = 10;
`endif
   localparam int MSG_CYC = 7 * FB * CPB;     // 700, or 770 with parity
   localparam int NCAP    = MSG_CYC + 30;
   localparam int MAXC    = 1000;

   logic       clk = 1'b0;
   logic       reset;
   logic       send;
   logic       tx;
   logic       busy;
   logic       done;
   logic [7:0] tx_byte;
   logic [2:0] byte_idx;

   int tests = 0;
   int fails = 0;

   logic       tx_log   [1:MAXC];
   logic       busy_log [1:MAXC];
   logic       done_log [1:MAXC];
   logic [7:0] byte_log [1:MAXC];
   logic [2:0] idx_log  [1:MAXC];

   logic [7:0] exp_msg [7] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D, 8'h0A};
   logic       exp_par [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   typedef struct {
      int         cyc;
      logic       tx;
      logic       busy;
      logic       done;
      logic [2:0] idx;
      logic [7:0] data;
   } vec_t;

   vec_t vecs[$];

   uart_hello_sender #(.CLK_FREQ(1000), .BAUD(100)) dut (
      .clk      (clk),
      .reset    (reset),
      .send     (send),
      .tx       (tx),
      .busy     (busy),
      .done     (done),
      .tx_byte  (tx_byte),
      .byte_idx (byte_idx)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive send high for cycles 0..hold-1 and in cycle inject, log outputs
   // for cycles 1..n.
   task automatic capture(input int n, input int hold, input int inject);
      for (int c = 0; c < n; c++) begin
         send = (c < hold) || (c == inject);
         tick();
         tx_log[c+1]   = tx;
         busy_log[c+1] = busy;
         done_log[c+1] = done;
         byte_log[c+1] = tx_byte;
         idx_log[c+1]  = byte_idx;
      end
      send = 1'b0;
   endtask

   // Decode the logged line at mid-bit and check the whole message framing.
   task automatic check_message(input string tag);
      int base;
      int done_cnt;
      int done_at;
      int busy_bad;
      int idle_bad;
      int idx_bad;
      logic [7:0] rx;
      for (int f = 0; f < 7; f++) begin
         base = 1 + f * FB * CPB;
         check($sformatf("%s_start%0d", tag, f), tx_log[base + 5], 1'b0);
         for (int b = 0; b < 8; b++) rx[b] = tx_log[base + (1 + b) * CPB + 5];
         check($sformatf("%s_byte%0d", tag, f), rx, exp_msg[f]);
`ifdef UART_TX_PARITY_EN
         check($sformatf("%s_parity%0d", tag, f), tx_log[base + 9 * CPB + 5], exp_par[f]);
`endif
         check($sformatf("%s_stop%0d", tag, f), tx_log[base + (FB - 1) * CPB + 5], 1'b1);
      end
      done_cnt = 0;
      done_at  = 0;
      busy_bad = 0;
      idle_bad = 0;
      idx_bad  = 0;
      for (int c = 1; c <= NCAP; c++) begin
         if (done_log[c] === 1'b1) begin
            done_cnt++;
            if (done_at == 0) done_at = c;
         end
         if (busy_log[c] !== (c <= MSG_CYC)) busy_bad++;
         if (c > MSG_CYC && tx_log[c] !== 1'b1) idle_bad++;
         if (idx_log[c] > 3'd6) idx_bad++;
      end
      check($sformatf("%s_done_count", tag), done_cnt, 1);
      check($sformatf("%s_done_cycle", tag), done_at, MSG_CYC + 1);
      check($sformatf("%s_busy_window_errs", tag), busy_bad, 0);
      check($sformatf("%s_idle_after_errs", tag), idle_bad, 0);
      check($sformatf("%s_idx_range_errs", tag), idx_bad, 0);
   endtask

   initial begin
      // Frame-0 timing and completion vectors for a single send.
      vecs.push_back('{1,  1'b0, 1'b1, 1'b0, 3'd0, 8'h68});
      vecs.push_back('{10, 1'b0, 1'b1, 1'b0, 3'd0, 8'h68});
      vecs.push_back('{11, 1'b0, 1'b1, 1'b0, 3'd0, 8'h68});
      vecs.push_back('{20, 1'b0, 1'b1, 1'b0, 3'd0, 8'h68});
      vecs.push_back('{31, 1'b0, 1'b1, 1'b0, 3'd0, 8'h68});
      vecs.push_back('{41, 1'b1, 1'b1, 1'b0, 3'd0, 8'h68});
      vecs.push_back('{50, 1'b1, 1'b1, 1'b0, 3'd0, 8'h68});
      vecs.push_back('{51, 1'b0, 1'b1, 1'b0, 3'd0, 8'h68});
      vecs.push_back('{61, 1'b1, 1'b1, 1'b0, 3'd0, 8'h68});
      vecs.push_back('{71, 1'b1, 1'b1, 1'b0, 3'd0, 8'h68});
      vecs.push_back('{81, 1'b0, 1'b1, 1'b0, 3'd0, 8'h68});
      vecs.push_back('{90, 1'b0, 1'b1, 1'b0, 3'd0, 8'h68});
`ifdef UART_TX_PARITY_EN
      vecs.push_back('{91,  1'b1, 1'b1, 1'b0, 3'd0, 8'h68});   // parity of 0x68
      vecs.push_back('{101, 1'b1, 1'b1, 1'b0, 3'd0, 8'h68});
      vecs.push_back('{110, 1'b1, 1'b1, 1'b0, 3'd0, 8'h68});
      vecs.push_back('{111, 1'b0, 1'b1, 1'b0, 3'd1, 8'h65});
`else
      vecs.push_back('{91,  1'b1, 1'b1, 1'b0, 3'd0, 8'h68});
      vecs.push_back('{100, 1'b1, 1'b1, 1'b0, 3'd0, 8'h68});
      vecs.push_back('{101, 1'b0, 1'b1, 1'b0, 3'd1, 8'h65});
`endif
      vecs.push_back('{MSG_CYC,      1'b1, 1'b1, 1'b0, 3'd6, 8'h0A});
      vecs.push_back('{MSG_CYC + 1,  1'b1, 1'b0, 1'b1, 3'd6, 8'h0A});
      vecs.push_back('{MSG_CYC + 2,  1'b1, 1'b0, 1'b0, 3'd6, 8'h0A});
      vecs.push_back('{MSG_CYC + 20, 1'b1, 1'b0, 1'b0, 3'd6, 8'h0A});

      // Reset values, then 50 idle cycles.
      reset = 1'b1;
      send  = 1'b0;
      tick();
      tick();
      check("rst_tx", tx, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_byte", tx_byte, 8'h00);
      check("rst_idx", byte_idx, 3'd0);
      reset = 1'b0;
      for (int c = 0; c < 50; c++) begin
         tick();
         check("idle_tx", tx, 1'b1);
         check("idle_busy", busy, 1'b0);
         check("idle_done", done, 1'b0);
         check("idle_idx", byte_idx, 3'd0);
      end

      // Single send: vector table plus full decode.
      capture(NCAP, 1, -1);
      foreach (vecs[i]) begin
         check($sformatf("vec%0d_c%0d_tx", i, vecs[i].cyc), tx_log[vecs[i].cyc], vecs[i].tx);
         check($sformatf("vec%0d_c%0d_busy", i, vecs[i].cyc), busy_log[vecs[i].cyc], vecs[i].busy);
         check($sformatf("vec%0d_c%0d_done", i, vecs[i].cyc), done_log[vecs[i].cyc], vecs[i].done);
         check($sformatf("vec%0d_c%0d_idx", i, vecs[i].cyc), idx_log[vecs[i].cyc], vecs[i].idx);
         check($sformatf("vec%0d_c%0d_byte", i, vecs[i].cyc), byte_log[vecs[i].cyc], vecs[i].data);
      end
      check_message("single");

      // Second send mid-message is dropped.
      capture(NCAP, 1, 300);
      check_message("ignored");

      // send held for 3 cycles starts exactly one message.
      capture(NCAP, 3, -1);
      check_message("held");

      // send during the done cycle (finish state) is dropped.
      capture(NCAP, 1, MSG_CYC + 1);
      check_message("finish_send");

      // send the cycle after done starts a new message.
      capture(MSG_CYC + 5, 1, MSG_CYC + 2);
      check("redo_done", done_log[MSG_CYC + 1], 1'b1);
      check("redo_tx", tx_log[MSG_CYC + 3], 1'b0);
      check("redo_busy", busy_log[MSG_CYC + 3], 1'b1);
      check("redo_idx", idx_log[MSG_CYC + 3], 3'd0);
      check("redo_byte", byte_log[MSG_CYC + 3], 8'h68);

      // Reset mid byte 2 aborts at once; a fresh send restarts from 0x68.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      send = 1'b1;
      tick();
      send = 1'b0;
      repeat (249) tick();
      check("mid_idx_before", byte_idx, 3'd2);
      reset = 1'b1;
      #1;
      check("abort_tx", tx, 1'b1);
      check("abort_busy", busy, 1'b0);
      check("abort_idx", byte_idx, 3'd0);
      check("abort_byte", tx_byte, 8'h00);
      tick();
      reset = 1'b0;
      tick();
      check("post_abort_tx", tx, 1'b1);
      check("post_abort_busy", busy, 1'b0);
      capture(NCAP, 1, -1);
      check("restart_byte", byte_log[1], 8'h68);
      check_message("restart");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
